// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI-lite arbiter with round-robin grant.
// One transaction (read or write) is outstanding at a time; the grant is released on the R or B handshake.
module axi_lite_rr_arbiter #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M*ADDR_W-1:0]    m_araddr,
    input  logic [NUM_M-1:0]           m_arvalid,
    output logic [NUM_M-1:0]           m_arready,
    output logic [NUM_M*DATA_W-1:0]    m_rdata,
    output logic [NUM_M*2-1:0]         m_rresp,
    output logic [NUM_M-1:0]           m_rvalid,
    input  logic [NUM_M-1:0]           m_rready,
    input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
    input  logic [NUM_M-1:0]           m_awvalid,
    output logic [NUM_M-1:0]           m_awready,
    input  logic [NUM_M*DATA_W-1:0]    m_wdata,
    input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
    input  logic [NUM_M-1:0]           m_wvalid,
    output logic [NUM_M-1:0]           m_wready,
    output logic [NUM_M*2-1:0]         m_bresp,
    output logic [NUM_M-1:0]           m_bvalid,
    input  logic [NUM_M-1:0]           m_bready,
    output logic [ADDR_W-1:0]          s_araddr,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    input  logic [1:0]                 s_bresp,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    output logic [NUM_M-1:0]           grant
);

    localparam int unsigned IDX_W = $clog2(NUM_M);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_M - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ar_done_q, ar_done_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic [NUM_M-1:0] req;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] scan;
    logic             found;
    logic             rd_act;
    logic             wr_act;

    logic [ADDR_W-1:0] araddr_a [NUM_M];
    logic [ADDR_W-1:0] awaddr_a [NUM_M];
    logic [DATA_W-1:0] wdata_a  [NUM_M];
    logic [STRB_W-1:0] wstrb_a  [NUM_M];

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (x == LAST) ? '0 : x + IDX_W'(1);
    endfunction

    assign req    = m_arvalid | m_awvalid;
    assign rd_act = (state_q == S_READ);
    assign wr_act = (state_q == S_WRITE);

    // Round-robin search starting at ptr, wrapping at NUM_M.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = ptr_q;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
            scan = wrap_inc(scan);
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (found) begin
                    g_d     = pick;
                    ptr_d   = wrap_inc(pick);
                    state_d = m_arvalid[pick] ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                if (s_arvalid && s_arready) ar_done_d = 1'b1;
                if (s_rvalid && s_rready)   state_d   = S_IDLE;
            end
            S_WRITE: begin
                if (s_awvalid && s_awready) aw_done_d = 1'b1;
                if (s_wvalid && s_wready)   w_done_d  = 1'b1;
                if (s_bvalid && s_bready)   state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Slave-side forwarding through the grant mux.
    assign s_araddr  = rd_act ? araddr_a[g_q] : '0;
    assign s_arvalid = rd_act & m_arvalid[g_q] & ~ar_done_q;
    assign s_rready  = rd_act & m_rready[g_q];
    assign s_awaddr  = wr_act ? awaddr_a[g_q] : '0;
    assign s_awvalid = wr_act & m_awvalid[g_q] & ~aw_done_q;
    assign s_wdata   = wr_act ? wdata_a[g_q] : '0;
    assign s_wstrb   = wr_act ? wstrb_a[g_q] : '0;
    assign s_wvalid  = wr_act & m_wvalid[g_q] & ~w_done_q;
    assign s_bready  = wr_act & m_bready[g_q];

    // Per-master slicing and return-path routing; non-owners see zeros.
    for (genvar i = 0; i < NUM_M; i++) begin : g_master
        logic sel_rd;
        logic sel_wr;

        assign araddr_a[i] = m_araddr[i*ADDR_W +: ADDR_W];
        assign awaddr_a[i] = m_awaddr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i]  = m_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i]  = m_wstrb[i*STRB_W +: STRB_W];

        assign sel_rd   = rd_act && (g_q == IDX_W'(i));
        assign sel_wr   = wr_act && (g_q == IDX_W'(i));
        assign grant[i] = (state_q != S_IDLE) && (g_q == IDX_W'(i));

        assign m_arready[i]             = sel_rd & s_arready & ~ar_done_q;
        assign m_rdata[i*DATA_W +: DATA_W] = sel_rd ? s_rdata : '0;
        assign m_rresp[i*2 +: 2]        = sel_rd ? s_rresp : 2'b00;
        assign m_rvalid[i]              = sel_rd & s_rvalid;
        assign m_awready[i]             = sel_wr & s_awready & ~aw_done_q;
        assign m_wready[i]              = sel_wr & s_wready & ~w_done_q;
        assign m_bresp[i*2 +: 2]        = sel_wr ? s_bresp : 2'b00;
        assign m_bvalid[i]              = sel_wr & s_bvalid;
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Randomized bench for axi_lite_rr_arbiter (4 masters, 32-bit data) against a transaction-level
// arbitration model with a behavioural slave and masters.
module tb_axi_lite_rr_arbiter;

    localparam int unsigned NUM_M  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int          NM     = NUM_M;
    localparam int          CYCLES = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_M*ADDR_W-1:0] m_araddr;
    logic [NUM_M-1:0]        m_arvalid, m_arready;
    logic [NUM_M*DATA_W-1:0] m_rdata;
    logic [NUM_M*2-1:0]      m_rresp;
    logic [NUM_M-1:0]        m_rvalid, m_rready;
    logic [NUM_M*ADDR_W-1:0] m_awaddr;
    logic [NUM_M-1:0]        m_awvalid, m_awready;
    logic [NUM_M*DATA_W-1:0] m_wdata;
    logic [NUM_M*STRB_W-1:0] m_wstrb;
    logic [NUM_M-1:0]        m_wvalid, m_wready;
    logic [NUM_M*2-1:0]      m_bresp;
    logic [NUM_M-1:0]        m_bvalid, m_bready;
    logic [ADDR_W-1:0]       s_araddr, s_awaddr;
    logic                    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DATA_W-1:0]       s_rdata, s_wdata;
    logic [1:0]              s_rresp, s_bresp;
    logic                    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [STRB_W-1:0]       s_wstrb;
    logic [NUM_M-1:0]        grant;

    axi_lite_rr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural masters
    bit                rd_pend [NUM_M], wr_pend [NUM_M];
    bit                ar_sent [NUM_M], aw_sent [NUM_M], w_sent [NUM_M];
    logic [ADDR_W-1:0] ar_a [NUM_M], aw_a [NUM_M];
    logic [DATA_W-1:0] w_d [NUM_M];
    logic [STRB_W-1:0] w_s [NUM_M];

    // Behavioural slave
    bit                sl_r_pend, sl_rv, sl_aw_got, sl_w_got, sl_bv;
    int                sl_r_cnt, sl_b_cnt;
    logic [DATA_W-1:0] sl_rdata;
    logic [1:0]        sl_rresp, sl_bresp;

    // Arbitration model: owner, kind, and pointer as plain integers
    bit busy, is_rd, ar_done, aw_done, w_done;
    int owner, ptr, busy_cycles;
    int wait_cnt [NUM_M];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NM; i++) begin
            rd_pend[i] = 0; wr_pend[i] = 0; ar_sent[i] = 0; aw_sent[i] = 0; w_sent[i] = 0;
            wait_cnt[i] = 0;
        end
        sl_r_pend = 0; sl_rv = 0; sl_aw_got = 0; sl_w_got = 0; sl_bv = 0;
        sl_r_cnt = 0; sl_b_cnt = 0;
        busy = 0; is_rd = 0; ar_done = 0; aw_done = 0; w_done = 0;
        owner = 0; ptr = 0; busy_cycles = 0;
    endtask

    task automatic all_read();
        for (int i = 0; i < NM; i++) begin
            rd_pend[i] = 1; ar_a[i] = $urandom;
        end
    endtask

    task automatic advance();
        for (int i = 0; i < NM; i++) begin
            if (!rd_pend[i] && $urandom_range(0, 3) == 0) begin
                rd_pend[i] = 1; ar_a[i] = $urandom;
            end
            if (!wr_pend[i] && $urandom_range(0, 3) == 0) begin
                wr_pend[i] = 1; aw_a[i] = $urandom; w_d[i] = $urandom; w_s[i] = STRB_W'($urandom);
            end
        end
        if (sl_r_pend && !sl_rv) begin
            if (sl_r_cnt == 0) sl_rv = 1; else sl_r_cnt--;
        end
        if (sl_aw_got && sl_w_got && !sl_bv) begin
            if (sl_b_cnt == 0) sl_bv = 1; else sl_b_cnt--;
        end
    endtask

    task automatic drive_inputs(input bit in_rst);
        rst = in_rst ? 1'b0 : 1'b1;
        for (int i = 0; i < NM; i++) begin
            m_arvalid[i] = !in_rst && rd_pend[i] && !ar_sent[i];
            m_awvalid[i] = !in_rst && wr_pend[i] && !aw_sent[i];
            m_wvalid[i]  = !in_rst && wr_pend[i] && !w_sent[i];
            m_araddr[i*ADDR_W +: ADDR_W] = ar_a[i];
            m_awaddr[i*ADDR_W +: ADDR_W] = aw_a[i];
            m_wdata[i*DATA_W +: DATA_W]  = w_d[i];
            m_wstrb[i*STRB_W +: STRB_W]  = w_s[i];
            m_rready[i] = ($urandom_range(0, 3) != 0);
            m_bready[i] = ($urandom_range(0, 3) != 0);
        end
        s_arready = 1'($urandom_range(0, 1));
        s_awready = 1'($urandom_range(0, 1));
        s_wready  = 1'($urandom_range(0, 1));
        s_rvalid  = !in_rst && sl_rv;
        s_rdata   = s_rvalid ? sl_rdata : '0;
        s_rresp   = s_rvalid ? sl_rresp : 2'b00;
        s_bvalid  = !in_rst && sl_bv;
        s_bresp   = s_bvalid ? sl_bresp : 2'b00;
    endtask

    logic [NUM_M-1:0]        e_grant, e_arready, e_rvalid, e_awready, e_wready, e_bvalid;
    logic [NUM_M*DATA_W-1:0] e_rdata;
    logic [NUM_M*2-1:0]      e_rresp, e_bresp;
    logic [ADDR_W-1:0]       e_araddr, e_awaddr;
    logic [DATA_W-1:0]       e_wdata;
    logic [STRB_W-1:0]       e_wstrb;
    logic                    e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready;

    initial begin
        bit rdv, wrv, do_rst, did_rst, first_pend, first_next;
        logic [NUM_M-1:0] rq;
        int j;

        clear_all();
        for (int i = 0; i < NM; i++) begin
            ar_a[i] = '0; aw_a[i] = '0; w_d[i] = '0; w_s[i] = '0;
        end
        sl_rdata = '0; sl_rresp = 2'b00; sl_bresp = 2'b00;
        drive_inputs(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_s_out", {s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb,
                          s_wvalid, s_bready}, 0);
        chk("rst_m_out", {m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp,
                          m_bvalid}, 0);

        all_read();
        do_rst = 0; did_rst = 0; first_pend = 1; first_next = 0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            if (do_rst) begin
                drive_inputs(1);
                clear_all();
                all_read();
                do_rst = 0; first_pend = 1;
                continue;
            end
            advance();
            drive_inputs(0);
            #1;

            rdv = busy && is_rd;
            wrv = busy && !is_rd;
            e_grant = '0; e_arready = '0; e_rvalid = '0; e_awready = '0; e_wready = '0;
            e_bvalid = '0; e_rdata = '0; e_rresp = '0; e_bresp = '0;
            if (busy) e_grant[owner] = 1'b1;
            e_arvalid = rdv && m_arvalid[owner] && !ar_done;
            e_araddr  = rdv ? ar_a[owner] : '0;
            e_rready  = rdv && m_rready[owner];
            e_awvalid = wrv && m_awvalid[owner] && !aw_done;
            e_awaddr  = wrv ? aw_a[owner] : '0;
            e_wvalid  = wrv && m_wvalid[owner] && !w_done;
            e_wdata   = wrv ? w_d[owner] : '0;
            e_wstrb   = wrv ? w_s[owner] : '0;
            e_bready  = wrv && m_bready[owner];
            if (rdv) begin
                e_arready[owner] = s_arready && !ar_done;
                e_rdata[owner*DATA_W +: DATA_W] = s_rdata;
                e_rresp[owner*2 +: 2] = s_rresp;
                e_rvalid[owner] = s_rvalid;
            end
            if (wrv) begin
                e_awready[owner] = s_awready && !aw_done;
                e_wready[owner]  = s_wready && !w_done;
                e_bresp[owner*2 +: 2] = s_bresp;
                e_bvalid[owner] = s_bvalid;
            end

            if (first_next) begin
                chk("first_grant", grant, 256'd1);
                first_next = 0;
            end
            chk("grant", grant, e_grant);
            chk("s_rd", {s_araddr, s_arvalid, s_rready}, {e_araddr, e_arvalid, e_rready});
            chk("s_wr", {s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready},
                        {e_awaddr, e_awvalid, e_wdata, e_wstrb, e_wvalid, e_bready});
            chk("m_rd", {m_arready, m_rdata, m_rresp, m_rvalid}, {e_arready, e_rdata, e_rresp, e_rvalid});
            chk("m_wr", {m_awready, m_wready, m_bresp, m_bvalid}, {e_awready, e_wready, e_bresp, e_bvalid});

            if (!busy) begin
                rq = m_arvalid | m_awvalid;
                if (rq != '0) begin
                    j = -1;
                    for (int k = 0; k < NM; k++)
                        if (j < 0 && rq[(ptr + k) % NM]) j = (ptr + k) % NM;
                    for (int i = 0; i < NM; i++)
                        if (i != j && rq[i]) wait_cnt[i]++;
                    chk("starve", 256'(wait_cnt[j] <= NM - 1), 256'd1);
                    wait_cnt[j] = 0;
                    owner = j; ptr = (j + 1) % NM; is_rd = m_arvalid[j];
                    busy = 1; ar_done = 0; aw_done = 0; w_done = 0; busy_cycles = 0;
                    if (first_pend) begin first_next = 1; first_pend = 0; end
                end
            end else if (is_rd) begin
                if (e_arvalid && s_arready) begin
                    ar_done = 1; ar_sent[owner] = 1; sl_r_pend = 1;
                    sl_r_cnt = $urandom_range(0, 3); sl_rdata = $urandom; sl_rresp = 2'($urandom);
                end
                if (sl_rv && m_rready[owner]) begin
                    rd_pend[owner] = 0; ar_sent[owner] = 0; sl_rv = 0; sl_r_pend = 0; busy = 0;
                end
            end else begin
                if (e_awvalid && s_awready) begin aw_done = 1; aw_sent[owner] = 1; sl_aw_got = 1; end
                if (e_wvalid && s_wready) begin w_done = 1; w_sent[owner] = 1; sl_w_got = 1; end
                if (sl_aw_got && sl_w_got && !sl_bv && sl_b_cnt == 0 && (aw_done || w_done)) begin
                    sl_b_cnt = $urandom_range(0, 3); sl_bresp = 2'($urandom);
                end
                if (sl_bv && m_bready[owner]) begin
                    wr_pend[owner] = 0; aw_sent[owner] = 0; w_sent[owner] = 0;
                    sl_bv = 0; sl_aw_got = 0; sl_w_got = 0; busy = 0;
                end
            end

            if (busy) begin
                busy_cycles++;
                if (busy_cycles > 64) begin
                    chk("watchdog", 256'(busy_cycles), 256'd64);
                    busy_cycles = 0;
                end
            end
            if (!did_rst && cyc > CYCLES / 2 && busy && !is_rd && aw_done) begin
                do_rst = 1; did_rst = 1;
            end
        end
        chk("mid_rst_seen", 256'(did_rst), 256'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
